uart_tx_arb: RTL

Arbitration and sequencing controller in front of the UART transmit byte engine. It shares one serial TX datapath between up to NUM_REQ word-level requesters: CPU store path, debug/trace port, DMA and similar. Each requester hands over a 32-bit word plus a byte count through a valid/ready handshake. The block then feeds the engine one byte at a time, least-significant byte first, using a start/busy/done handshake, and reports completion per word.

---
 rtl/uart_tx_arb.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// ----------------------------------------------------------------------------
// uart_tx_arb
//
// Arbitration and sequencing controller that shares one UART transmit byte
// engine between NUM_REQ word-level requesters. A granted requester hands
// over a 32-bit word and a byte count. The word is then fed to the engine
// one byte at a time, least-significant byte first. Completion is reported
// once per word.
//
// Configuration macro:
//   UART_TX_ARB_FIXED_PRI_EN - when defined, the lowest requester index always
//                              wins and rr_ptr is held at 0. When undefined
//                              (the default), round-robin arbitration starts
//                              the search at rr_ptr.
//
// Parameters:
//   NUM_REQ       number of requesters (2..8)
//   GID_W         requester ID width, 2**GID_W >= NUM_REQ
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester word valid, held until accepted
//   req_data      32-bit word per requester, requester i at [32i+31:32i]
//   req_len       byte count minus one per requester, requester i at [2i+1:2i]
//   req_ready     registered one-hot accept
//   tx_start      one-cycle start pulse to the byte engine
//   tx_byte       byte for the engine, stable from tx_start to the next start
//   tx_busy       engine is serialising
//   tx_done       engine finished the stop bit (one-cycle pulse)
//   arb_busy      controller is not idle
//   grant_id      requester currently granted or being served
//   word_done     one-cycle pulse when the last byte of a word completes
//   word_done_id  requester ID qualified by word_done
// ----------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_data,
    input  logic [NUM_REQ*2-1:0]   req_len,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_byte,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   arb_busy,
    output logic [GID_W-1:0]       grant_id,
    output logic                   word_done,
    output logic [GID_W-1:0]       word_done_id
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SEND,
        WAIT
    } state_t;

    localparam logic [GID_W:0]   NUM_REQ_X = (GID_W+1)'(NUM_REQ);
    localparam logic [GID_W-1:0] LAST_ID   = GID_W'(NUM_REQ - 1);

    state_t             state;
    logic [GID_W-1:0]   rr_ptr;
    logic [31:0]        shift_reg;
    logic [1:0]         len;
    logic [1:0]         byte_cnt;

    logic [GID_W-1:0]   winner;
    logic [NUM_REQ-1:0] winner_oh;
    logic [GID_W:0]     probe;
    logic               found;

    logic               sel_valid;
    logic [31:0]        sel_data;
    logic [1:0]         sel_len;

    logic [GID_W-1:0]   next_rr;

    // Round-robin search: probe indices rr_ptr, rr_ptr+1, ... with an explicit
    // wrap at NUM_REQ so non-power-of-2 requester counts never probe a
    // nonexistent index. The first valid requester found wins. probe is one
    // bit wider than an ID so the sum before the wrap cannot overflow.
    always_comb begin
        winner    = '0;
        winner_oh = '0;
        found     = 1'b0;
        probe     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = {1'b0, rr_ptr} + (GID_W+1)'(k);
            if (probe >= NUM_REQ_X) begin
                probe = probe - NUM_REQ_X;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req_valid[j] && (probe == (GID_W+1)'(j))) begin
                    found        = 1'b1;
                    winner       = GID_W'(j);
                    winner_oh[j] = 1'b1;
                end
            end
        end
    end

    // Select the valid, word and length of the currently granted requester,
    // used to confirm the handshake and capture the word in GRANT.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_len   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id == GID_W'(j)) begin
                sel_valid = req_valid[j];
                sel_data  = req_data[32*j +: 32];
                sel_len   = req_len[2*j +: 2];
            end
        end
    end

    // Pointer value after a completed word: the requester after the one just
    // served. Fixed priority keeps the search anchored at requester 0.
`ifdef UART_TX_ARB_FIXED_PRI_EN
    assign next_rr = '0;
`else
    assign next_rr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
`endif

    // Main sequencer. All outputs are registered here, so no input reaches an
    // output combinationally. tx_start and word_done default low every cycle,
    // which makes them single-cycle pulses. An aborted grant (valid dropped
    // during GRANT) returns to IDLE without touching rr_ptr, so the same
    // requester order is searched again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            shift_reg    <= '0;
            len          <= '0;
            byte_cnt     <= '0;
            req_ready    <= '0;
            tx_start     <= 1'b0;
            tx_byte      <= 8'h00;
            arb_busy     <= 1'b0;
            grant_id     <= '0;
            word_done    <= 1'b0;
            word_done_id <= '0;
        end else begin
            tx_start  <= 1'b0;
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= winner;
                        req_ready <= winner_oh;
                        arb_busy  <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    req_ready <= '0;
                    if (sel_valid) begin
                        shift_reg <= sel_data;
                        len       <= sel_len;
                        byte_cnt  <= '0;
                        state     <= SEND;
                    end else begin
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_byte  <= shift_reg[7:0];
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (byte_cnt == len) begin
                            word_done    <= 1'b1;
                            word_done_id <= grant_id;
                            rr_ptr       <= next_rr;
                            arb_busy     <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            shift_reg <= {8'h00, shift_reg[31:8]};
                            byte_cnt  <= byte_cnt + 2'd1;
                            state     <= SEND;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
